// File: rtl/datapath_pkg.sv
// ---------------------------------------------------------------------------
// datapath_pkg
// Definitions shared by the fetch stage and its program-counter register.
//   XLEN          : datapath word width in bits
//   word_t        : one XLEN-bit datapath word
//   RESET_PC_DEF  : default program counter after reset
//   PC_STEP_DEF   : default byte increment for a sequential fetch
//   NOP_INSTR_DEF : default instruction word used for bubbles
//   align_word()  : clears the two low bits of a byte address
// ---------------------------------------------------------------------------
package datapath_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEF  = 32'h0000_0000;
    localparam word_t PC_STEP_DEF   = 32'd4;
    localparam word_t NOP_INSTR_DEF = 32'h0000_0000;

    // Redirect targets can carry junk in the low bits; fetch is always
    // word-aligned, so those bits are discarded rather than trapped.
    function automatic word_t align_word(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register with its next-PC selection.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   stall        : hold the PC
//   redirect     : load the aligned redirect_pc (beats stall)
//   redirect_pc  : redirect byte address
//   pc           : current program counter (registered)
//   pc_plus_step : pc + PC_STEP (combinational, wraps modulo 2^XLEN)
// ---------------------------------------------------------------------------
module pc_reg
    import datapath_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEF,
    parameter word_t PC_STEP  = PC_STEP_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    output word_t pc,
    output word_t pc_plus_step
);

    word_t pc_d;

    // Plain XLEN-bit add, so the last word of the address space wraps to 0.
    assign pc_plus_step = pc + PC_STEP;

    // A redirect must never be lost to a stall: it is checked first.
    always_comb begin
        pc_d = pc_plus_step;
        if (redirect) begin
            pc_d = align_word(redirect_pc);
        end else if (stall) begin
            pc_d = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the returned word into the IF/ID register with its PC and PC+step.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   stall        : hold PC, IF/ID and fetch_count
//   flush        : replace IF/ID with a bubble on the next edge
//   redirect     : load redirect_pc into PC and bubble IF/ID
//   redirect_pc  : redirect byte address (low two bits ignored)
//   imem_addr    : instruction memory byte address (= pc, combinational)
//   imem_data    : instruction word read combinationally from imem_addr
//   if_instr     : registered instruction for decode
//   if_pc        : PC of if_instr
//   if_pc4       : if_pc + PC_STEP
//   if_valid     : 1 = if_instr is real, 0 = bubble
//   fetch_count  : number of valid instructions loaded into IF/ID
//
// Downstream control: stall, flush and redirect are level signals sampled at
// each rising edge. Priority at that edge is rst, then flush/redirect (bubble),
// then stall (hold), otherwise a normal load. There is no handshake back to
// the consumer; if_valid alone marks which IF/ID contents are meaningful.
// ---------------------------------------------------------------------------
module fetch_stage
    import datapath_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEF,
    parameter word_t PC_STEP   = PC_STEP_DEF,
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect,
    input  word_t redirect_pc,
    output word_t imem_addr,
    input  word_t imem_data,
    output word_t if_instr,
    output word_t if_pc,
    output word_t if_pc4,
    output logic  if_valid,
    output word_t fetch_count
);

    word_t pc;
    word_t pc_plus_step;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc           (pc),
        .pc_plus_step (pc_plus_step)
    );

    assign imem_addr = pc;

    // On a bubble the PC fields still track the current pc; decode ignores
    // them (if_valid=0) but they make traces easier to follow.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_instr    <= NOP_INSTR;
            if_pc       <= '0;
            if_pc4      <= '0;
            if_valid    <= 1'b0;
            fetch_count <= '0;
        end else if (flush || redirect) begin
            if_instr    <= NOP_INSTR;
            if_pc       <= pc;
            if_pc4      <= pc_plus_step;
            if_valid    <= 1'b0;
        end else if (!stall) begin
            if_instr    <= imem_data;
            if_pc       <= pc;
            if_pc4      <= pc_plus_step;
            if_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with a cycle-level reference model and a
// handful of literal expectations taken from the test plan.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_valid    (if_valid),
        .fetch_count (fetch_count)
    );

    // Instruction memory contents: a tag plus the word index, so every word
    // in the touched range is distinct and non-zero.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | ((a >> 2) & 32'h0000_FFFF);
    endfunction

    assign imem_data = mem_word(imem_addr);

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: a program counter and an IF/ID record.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        logic [31:0] cur_pc;
        cur_pc = m_pc;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
            m_valid = 1'b0; m_cnt = 32'h0;
            model_live = 1'b1;
        end else begin
            if (flush || redirect) begin
                m_instr = 32'h0; m_valid = 1'b0;
                m_ipc = cur_pc; m_ipc4 = cur_pc + 32'd4;
            end else if (!stall) begin
                m_instr = mem_word(cur_pc); m_valid = 1'b1;
                m_ipc = cur_pc; m_ipc4 = cur_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
            if (redirect)   m_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (!stall) m_pc = cur_pc + 32'd4;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("imem_addr",   imem_addr,   m_pc);
            check("if_instr",    if_instr,    m_instr);
            check("if_pc",       if_pc,       m_ipc);
            check("if_pc4",      if_pc4,      m_ipc4);
            check("if_valid",    {31'b0, if_valid}, {31'b0, m_valid});
            check("fetch_count", fetch_count, m_cnt);
        end
    end

    // ---------------- driver ----------------
    // Advance one edge, then settle just past the falling edge where the
    // literal checks and the next input changes happen.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic rd, input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    endtask

    initial begin
        // Reset two cycles.
        drive(1, 0, 0, 0, 32'h0);
        step();
        step();
        check("rst.addr",  imem_addr,   32'h0);
        check("rst.valid", {31'b0, if_valid}, 32'h0);
        check("rst.instr", if_instr,    32'h0);
        check("rst.count", fetch_count, 32'h0);

        // Sequential fetch.
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("seq0.instr", if_instr, 32'hC0DE_0000);
        check("seq0.pc",    if_pc,    32'h0);
        check("seq0.count", fetch_count, 32'd1);
        check("seq0.addr",  imem_addr, 32'h4);
        step();
        check("seq1.instr", if_instr, 32'hC0DE_0001);
        check("seq1.addr",  imem_addr, 32'h8);

        // Stall two cycles at pc=8.
        drive(0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall.addr",  imem_addr,   32'h8);
            check("stall.instr", if_instr,    32'hC0DE_0001);
            check("stall.pc",    if_pc,       32'h4);
            check("stall.count", fetch_count, 32'd2);
        end
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("unstall.instr", if_instr, 32'hC0DE_0002);
        check("unstall.count", fetch_count, 32'd3);
        check("unstall.addr",  imem_addr, 32'hC);

        // Misaligned redirect at pc=12.
        drive(0, 0, 0, 1, 32'h0000_0041);
        step();
        check("redir.addr",  imem_addr, 32'h40);
        check("redir.valid", {31'b0, if_valid}, 32'h0);
        check("redir.instr", if_instr, 32'h0);
        check("redir.count", fetch_count, 32'd3);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("redir.tgt_instr", if_instr, 32'hC0DE_0010);
        check("redir.tgt_pc",    if_pc,    32'h40);

        // Redirect and stall together: redirect wins.
        drive(0, 1, 0, 1, 32'h20);
        step();
        check("rdst.addr",  imem_addr, 32'h20);
        check("rdst.valid", {31'b0, if_valid}, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("rdst.instr", if_instr, 32'hC0DE_0008);
        check("rdst.count", fetch_count, 32'd5);

        // Mid-run reset with fetch_count=5.
        drive(1, 0, 0, 0, 32'h0);
        step();
        check("mrst.addr",  imem_addr,   32'h0);
        check("mrst.valid", {31'b0, if_valid}, 32'h0);
        check("mrst.count", fetch_count, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("mrst.w0",    if_instr,    32'hC0DE_0000);
        check("mrst.count1", fetch_count, 32'd1);

        // Flush with stall: bubble, PC holds.
        drive(0, 1, 1, 0, 32'h0);
        step();
        check("flst.addr",  imem_addr, 32'h4);
        check("flst.valid", {31'b0, if_valid}, 32'h0);
        check("flst.count", fetch_count, 32'd1);
        // Flush alone: bubble, PC advances.
        drive(0, 0, 1, 0, 32'h0);
        step();
        check("fl.addr",  imem_addr, 32'h8);
        check("fl.valid", {31'b0, if_valid}, 32'h0);
        // Flush with redirect: one bubble.
        drive(0, 0, 1, 1, 32'h100);
        step();
        check("flrd.addr", imem_addr, 32'h100);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("flrd.instr", if_instr, 32'hC0DE_0040);

        // Wrap at the top of the address space.
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        step();
        check("wrap.addr_top", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0);
        step();
        check("wrap.addr0", imem_addr, 32'h0);
        check("wrap.instr", if_instr,  32'hC0DE_FFFF);
        check("wrap.pc",    if_pc,     32'hFFFF_FFFC);
        check("wrap.pc4",   if_pc4,    32'h0);
        step();
        check("wrap.next",  if_instr,  32'hC0DE_0000);

        // Short directed mix of controls, checked by the per-cycle model.
        for (int i = 0; i < 40; i++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  32'($urandom_range(0, 255)));
            step();
        end

        drive(0, 0, 0, 0, 32'h0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the datapath's instruction memory and decode logic.
- Holds the program counter and drives the instruction-memory word address.
- Captures the returned instruction into an IF/ID pipeline register together with PC and PC+4.
- Supports stall, flush and branch/jump redirect from downstream, and counts instructions delivered.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on bubbles.

Ports:
- clk  in  1  single rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  replace IF/ID contents with a bubble next edge.
- redirect  in  1  load redirect_pc into PC (taken branch/jump).
- redirect_pc  in  32  redirect byte address.
- imem_addr  out  32  byte address to instruction memory (= pc).
- imem_data  in  32  instruction word; combinational read of imem_addr.
- if_instr  out  32  registered instruction to decode.
- if_pc  out  32  PC of if_instr.
- if_pc4  out  32  if_pc + PC_STEP.
- if_valid  out  1  if_instr is a real instruction (0 = bubble).
- fetch_count  out  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC.
  - if_instr=NOP_INSTR, if_pc=0, if_pc4=0, if_valid=0, fetch_count=0.
  - rst overrides all other inputs.
- imem_addr = pc, purely combinational. No other output is combinational.
- Latency: the word at address A appears on if_instr one edge after pc=A, provided there is no stall or redirect in that cycle.
- PC update priority per edge is rst > redirect > stall > sequential:
  - redirect=1: pc <= {redirect_pc[31:2],2'b00}. Misaligned low bits are silently cleared.
  - stall=1 (no redirect): pc holds.
  - otherwise: pc <= pc + PC_STEP, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update priority per edge is rst > (flush or redirect) > stall > load:
  - Bubble (flush=1 or redirect=1):
    - if_instr=NOP_INSTR, if_valid=0.
    - if_pc and if_pc4 are loaded with current pc and pc+PC_STEP, for debug only.
  - stall=1: all IF/ID fields and fetch_count hold.
  - Load:
    - if_instr=imem_data, if_pc=pc, if_pc4=pc+PC_STEP, if_valid=1.
    - fetch_count += 1, wrapping modulo 2^32.
- Simultaneous events:
  - redirect+stall: redirect wins. PC is redirected and IF/ID gets a bubble, so the stall never drops a redirect.
  - flush+stall (no redirect): IF/ID bubbles and PC holds.
  - flush+redirect: a single bubble.
- Reset mid-operation: the next edge returns to the reset state. The first valid instruction is the word at RESET_PC, one edge after rst deasserts.
- fetch_count increments only on the load path, never on bubble, hold or reset.
- There is no internal FSM beyond the pc and IF/ID registers. State is implied by (if_valid, stall).

Decomposition:
- Shared package datapath_pkg holds:
  - constants RESET_PC_DEF=32'h0, PC_STEP_DEF=4, NOP_INSTR_DEF=32'h0;
  - width constant XLEN=32;
  - typedef word_t (XLEN bits).
- Sub-module pc_reg contains the PC register, next-PC mux (redirect/stall/increment), alignment masking and reset.
- The IF/ID register and fetch counter live in fetch_stage top.

Test Plan:
- Sequential fetch from reset: rst high 2 cycles then low; imem preloaded with words W0..W3 at 0,4,8,12. Required response:
  - imem_addr steps 0,4,8,12;
  - if_instr=W0,W1,W2 with if_pc=0,4,8 and if_valid=1;
  - fetch_count=1,2,3.
- Stall: assert stall for 2 cycles while pc=8. Required response:
  - pc stays 8;
  - if_instr stays W1, if_pc stays 4;
  - fetch_count holds at 2;
  - after release, next if_instr=W2.
- Redirect: redirect=1, redirect_pc=32'h0000_0041 while pc=12. Required response:
  - next pc=32'h40;
  - if_valid=0 and if_instr=0 for one cycle;
  - then if_instr=mem[0x40], if_pc=32'h40.
- Redirect with stall together: stall=1, redirect=1, redirect_pc=32'h20. Required response: pc=32'h20 and a bubble on IF/ID; the stall is ignored.
- Wrap: redirect_pc=32'hFFFF_FFFC. Required response: after 2 unstalled edges pc=0, and if_pc4 for the 0xFFFF_FFFC instruction equals 0.
- Mid-run reset: rst pulsed while fetch_count=5. Required response:
  - next edge gives pc=RESET_PC, if_valid=0, fetch_count=0;
  - W0 reappears one edge after rst drops.
